// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period/high time of clk_in in sys_clk cycles and flags lock/err/timeout.
// Optional duty-cycle check enabled by defining CLK_DIV_MONITOR_DUTY_CHECK_EN.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 7,
    parameter int LOCK_CNT   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEAS = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
    localparam logic [4:0]       LOCK_N  = 5'(LOCK_CNT);

    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_shadow;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_err;
    logic             r_timeout;
    logic [3:0]       r_match;
    state_t           r_state;

    logic             w_rise;
    logic             w_fall;
    logic             w_sat;
    logic [CNT_W-1:0] w_meas_p;
    logic             w_match;
    state_t           w_state_nxt;
    logic [3:0]       w_match_nxt;
    logic             w_mv_nxt;
    logic             w_err_nxt;
    logic             w_to_nxt;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_fall   = ~r_s2 & r_s3;
    // Saturation is flagged on the cycle the counter reaches its maximum.
    assign w_sat    = (r_cnt == CNT_SAT);
    assign w_meas_p = r_cnt + CNT_W'(1);

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    localparam logic [CNT_W-1:0] HALF_LO = CNT_W'(EXP_PERIOD / 2);
    localparam logic [CNT_W-1:0] HALF_HI = CNT_W'((EXP_PERIOD + 1) / 2);
    assign w_match = (w_meas_p == EXP_P) &&
                     ((r_hi_shadow == HALF_LO) || (r_hi_shadow == HALF_HI));
`else
    assign w_match = (w_meas_p == EXP_P);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_mv_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_to_nxt    = 1'b0;
        if ((r_state != S_IDLE) && w_sat) begin
            w_to_nxt    = 1'b1;
            w_match_nxt = 4'd0;
            w_state_nxt = S_IDLE;
        end else if (w_rise) begin
            if (r_state == S_IDLE) begin
                w_state_nxt = S_MEAS;
            end else begin
                w_mv_nxt = 1'b1;
                if (w_match) begin
                    if (({1'b0, r_match} + 5'd1) >= LOCK_N) begin
                        w_match_nxt = LOCK_N[3:0];
                        w_state_nxt = S_LOCK;
                    end else begin
                        w_match_nxt = r_match + 4'd1;
                    end
                end else begin
                    w_err_nxt   = 1'b1;
                    w_match_nxt = 4'd0;
                    w_state_nxt = S_MEAS;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_cnt        <= '0;
            r_hi_shadow  <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_err        <= 1'b0;
            r_timeout    <= 1'b0;
            r_match      <= 4'd0;
            r_state      <= S_IDLE;
        end else begin
            r_s1 <= clk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= w_meas_p;
            end
            if (w_fall) begin
                r_hi_shadow <= (r_cnt == CNT_MAX) ? CNT_MAX : w_meas_p;
            end
            if (w_mv_nxt) begin
                r_period    <= w_meas_p;
                r_high_time <= r_hi_shadow;
            end
            r_meas_valid <= w_mv_nxt;
            r_err        <= w_err_nxt;
            r_timeout    <= w_to_nxt;
            r_match      <= w_match_nxt;
            r_state      <= w_state_nxt;
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign err        = r_err;
    assign timeout    = r_timeout;
    assign locked     = (r_state == S_LOCK);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: default instance (7/4) and a 5/1 instance.
module tb_clk_div_monitor;

`ifdef CLK_DIV_MONITOR_DUTY_CHECK_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       clk_in = 1'b0;
    logic       clk_in2 = 1'b0;
    logic [7:0] period, high_time, period2, high_time2;
    logic       meas_valid, locked, err, timeout;
    logic       meas_valid2, locked2, err2, timeout2;
    logic [1:0] dbg_state, dbg_state2;

    clk_div_monitor u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_in(clk_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .err(err), .timeout(timeout), .dbg_state(dbg_state)
    );

    clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(5), .LOCK_CNT(1)) u_dut5 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_in(clk_in2),
        .period(period2), .high_time(high_time2), .meas_valid(meas_valid2),
        .locked(locked2), .err(err2), .timeout(timeout2), .dbg_state(dbg_state2)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Event log sampled 1 ns after each rising edge.
    int         cyc = 0;
    int         n_mv = 0, n_err = 0, n_err_nomv = 0, n_to = 0, n_to_mv = 0;
    int         last_mv_cyc = 0, to_cyc = 0;
    int         n_mv2 = 0;
    logic       lk_q[$];
    logic       err_q[$];
    logic [7:0] per_q[$];
    logic       lk2_q[$];
    logic [7:0] per2_q[$];

    always @(posedge sys_clk) begin
        cyc++;
        #1;
        if (meas_valid) begin
            n_mv++;
            lk_q.push_back(locked);
            err_q.push_back(err);
            per_q.push_back(period);
            last_mv_cyc = cyc;
        end
        if (err) begin
            n_err++;
            if (!meas_valid) n_err_nomv++;
        end
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
            if (meas_valid) n_to_mv++;
        end
        if (meas_valid2) begin
            n_mv2++;
            lk2_q.push_back(locked2);
            per2_q.push_back(period2);
        end
    end

    // Starts aligned to a falling edge; one call = one clk_in period.
    task automatic drive(input int which, input int hi, input int lo);
        if (which == 0) clk_in = 1'b1; else clk_in2 = 1'b1;
        repeat (hi) @(negedge sys_clk);
        if (which == 0) clk_in = 1'b0; else clk_in2 = 1'b0;
        repeat (lo) @(negedge sys_clk);
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_period"}, 32'(period), 0);
        check_eq({pfx, "_high_time"}, 32'(high_time), 0);
        check_eq({pfx, "_meas_valid"}, 32'(meas_valid), 0);
        check_eq({pfx, "_locked"}, 32'(locked), 0);
        check_eq({pfx, "_err"}, 32'(err), 0);
        check_eq({pfx, "_timeout"}, 32'(timeout), 0);
    endtask

    int b, be, bt, lm, b2;

    initial begin
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_zero("rst");
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Divide-by-7, high 4: first rise silent, lock on 4th measurement.
        b = n_mv;
        drive(0, 4, 3);
        check_eq("first_rise_silent", 32'(n_mv - b), 0);
        repeat (4) drive(0, 4, 3);
        check_eq("p1_mv_count", 32'(n_mv - b), 4);
        check_eq("p1_period", 32'(period), 7);
        check_eq("p1_high_time", 32'(high_time), 4);
        check_eq("p1_lock_at_mv3", 32'(lk_q[b + 2]), 0);
        check_eq("p1_lock_at_mv4", 32'(lk_q[b + 3]), 1);
        check_eq("p1_err_count", 32'(n_err), 0);

        // One period stretched to 8.
        b = n_mv; be = n_err;
        drive(0, 4, 4);
        repeat (5) drive(0, 4, 3);
        check_eq("p2_mv_count", 32'(n_mv - b), 6);
        check_eq("p2_err_with_mv", 32'(err_q[b + 1]), 1);
        check_eq("p2_period_8", 32'(per_q[b + 1]), 8);
        check_eq("p2_lock_drop", 32'(lk_q[b + 1]), 0);
        check_eq("p2_err_count", 32'(n_err - be), 1);
        check_eq("p2_lock_at_good3", 32'(lk_q[b + 4]), 0);
        check_eq("p2_lock_at_good4", 32'(lk_q[b + 5]), 1);
        check_eq("p2_err_without_mv", 32'(n_err_nomv), 0);

        // clk_in stuck low.
        b = n_mv; bt = n_to; lm = last_mv_cyc;
        repeat (300) @(negedge sys_clk);
        check_eq("p3_timeout_once", 32'(n_to - bt), 1);
        check_eq("p3_timeout_delay", 32'(to_cyc - lm), 255);
        check_eq("p3_locked", 32'(locked), 0);
        check_eq("p3_no_mv", 32'(n_mv - b), 0);
        check_eq("p3_timeout_with_mv", 32'(n_to_mv), 0);
        drive(0, 4, 3);
        check_eq("p3_restart_silent", 32'(n_mv - b), 0);
        repeat (4) drive(0, 4, 3);
        check_eq("p3_relock_mv", 32'(n_mv - b), 4);
        check_eq("p3_relocked", 32'(locked), 1);
        check_eq("p3_no_more_timeout", 32'(n_to - bt), 1);

        // Period 7 with high time 1.
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        b = n_mv; be = n_err;
        repeat (5) drive(0, 1, 6);
        check_eq("p4_mv_count", 32'(n_mv - b), 4);
        check_eq("p4_period", 32'(period), 7);
        check_eq("p4_high_time", 32'(high_time), 1);
        check_eq("p4_err_count", 32'(n_err - be), DUTY ? 4 : 0);
        check_eq("p4_locked", 32'(locked), DUTY ? 0 : 1);

        // Reset mid-period while locked.
        repeat (6) drive(0, 4, 3);
        check_eq("p5_locked_before", 32'(locked), 1);
        clk_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_zero("midrst");
        repeat (2) @(negedge sys_clk);
        clk_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        b = n_mv;
        drive(0, 4, 3);
        check_eq("p5_first_rise_silent", 32'(n_mv - b), 0);
        drive(0, 4, 3);
        check_eq("p5_second_rise_mv", 32'(n_mv - b), 1);
        check_eq("p5_period", 32'(period), 7);

        // EXP_PERIOD = 5, LOCK_CNT = 1.
        b2 = n_mv2;
        repeat (2) drive(1, 3, 2);
        check_eq("d5_mv_count", 32'(n_mv2 - b2), 1);
        check_eq("d5_lock_at_mv1", 32'(lk2_q[b2]), 1);
        check_eq("d5_period", 32'(per2_q[b2]), 5);
        check_eq("d5_high_time", 32'(high_time2), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
